// File: rtl/drawbridge_ctrl.sv
// drawbridge_ctrl: controls a bascule road bridge. It clears road traffic,
// raises the span for boats, holds it up, then lowers it. It supervises the
// limit switches, the motor run time and the emergency stop.
//
// Ports
//   clk_i        rising-edge system clock
//   rst_ni       asynchronous active-low reset
//   request_i    boat passage request (level)
//   deck_i       deck occupancy sensors, 1 = occupied
//   top_limit_i  span fully raised
//   bot_limit_i  span fully lowered
//   estop_i      emergency stop
//   mt_o         raise motor on
//   md_o         lower motor on
//   al_o         alarm on
//   tfl_o        road traffic light, 1 = red
//   state_o      current state (DOWN=0 WARN=1 LIFT=2 UP=3 LOWER=4 FAULT=5)
//   fault_o      sticky fault indicator
//
// There is no handshake. All inputs are plain levels sampled on every rising
// edge. All outputs are registers that change on the same edge as state_o.
module drawbridge_ctrl #(
  parameter int N_DECK        = 4,
  parameter int CNT_W         = 8,
  parameter int CLEAR_TIME    = 8,
  parameter int HOLD_TIME     = 16,
  parameter int MOTOR_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              request_i,
  input  logic [N_DECK-1:0] deck_i,
  input  logic              top_limit_i,
  input  logic              bot_limit_i,
  input  logic              estop_i,
  output logic              mt_o,
  output logic              md_o,
  output logic              al_o,
  output logic              tfl_o,
  output logic [2:0]        state_o,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    S_DOWN  = 3'd0,
    S_WARN  = 3'd1,
    S_LIFT  = 3'd2,
    S_UP    = 3'd3,
    S_LOWER = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mt_q, mt_d;
  logic             md_q, md_d;
  logic             al_q, al_d;
  logic             tfl_q, tfl_d;
  logic             fault_q, fault_d;

  logic deck_busy;
  logic moving;
  logic timeout;

  assign deck_busy = |deck_i;
  assign moving    = (state_q == S_LIFT) || (state_q == S_LOWER);
  assign timeout   = moving && (cnt_q == MOTOR_LAST);

  // Next state. Fault causes are checked first, then normal progress.
  always_comb begin
    state_d = state_q;
    if (estop_i || (top_limit_i && bot_limit_i)) begin
      state_d = S_FAULT;
    end else if (timeout) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_DOWN:  if (request_i) state_d = S_WARN;
        // Withdrawing the request wins over a completed clearing period.
        S_WARN: begin
          if (!request_i)                              state_d = S_DOWN;
          else if (cnt_q == CLEAR_LAST && !deck_busy)  state_d = S_LIFT;
        end
        S_LIFT:  if (top_limit_i) state_d = S_UP;
        S_UP:    if (cnt_q >= HOLD_LAST && !request_i) state_d = S_LOWER;
        // A new request during lowering is ignored until the span is down.
        S_LOWER: if (bot_limit_i) state_d = S_DOWN;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Shared counter. In WARN an occupied deck restarts the clearing period.
  // While moving, an occupied deck pauses the motor, so the counter also
  // freezes. It then counts only motor-on cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_WARN && deck_busy) begin
      cnt_d = '0;
    end else if (moving && deck_busy) begin
      cnt_d = cnt_q;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output decode comes from the next state, so outputs change with state_o.
  // The motor enables are exclusive because each depends on its own state.
  always_comb begin
    mt_d    = 1'b0;
    md_d    = 1'b0;
    al_d    = 1'b0;
    tfl_d   = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      S_DOWN: ;
      S_WARN: begin
        al_d  = 1'b1;
        tfl_d = 1'b1;
      end
      S_LIFT: begin
        al_d  = 1'b1;
        tfl_d = 1'b1;
        mt_d  = !deck_busy;
      end
      S_UP: tfl_d = 1'b1;
      S_LOWER: begin
        al_d  = 1'b1;
        tfl_d = 1'b1;
        md_d  = !deck_busy;
      end
      default: begin
        al_d    = 1'b1;
        tfl_d   = 1'b1;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_DOWN;
      cnt_q   <= '0;
      mt_q    <= 1'b0;
      md_q    <= 1'b0;
      al_q    <= 1'b0;
      tfl_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mt_q    <= mt_d;
      md_q    <= md_d;
      al_q    <= al_d;
      tfl_q   <= tfl_d;
      fault_q <= fault_d;
    end
  end

  assign mt_o    = mt_q;
  assign md_o    = md_q;
  assign al_o    = al_q;
  assign tfl_o   = tfl_q;
  assign state_o = state_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// Directed testbench for drawbridge_ctrl with default parameters.
// Inputs are driven just after the falling edge.
// Outputs are checked at the falling edge that follows each rising edge.
module tb_drawbridge_ctrl;

  localparam logic [2:0] DOWN  = 3'd0;
  localparam logic [2:0] WARN  = 3'd1;
  localparam logic [2:0] LIFT  = 3'd2;
  localparam logic [2:0] UP    = 3'd3;
  localparam logic [2:0] LOWER = 3'd4;
  localparam logic [2:0] FAULT = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       request;
  logic [3:0] deck;
  logic       top_limit;
  logic       bot_limit;
  logic       estop;
  logic       mt, md, al, tfl, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  drawbridge_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .request_i   (request),
    .deck_i      (deck),
    .top_limit_i (top_limit),
    .bot_limit_i (bot_limit),
    .estop_i     (estop),
    .mt_o        (mt),
    .md_o        (md),
    .al_o        (al),
    .tfl_o       (tfl),
    .state_o     (state),
    .fault_o     (fault)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_state, input logic e_mt,
                            input logic e_md, input logic e_al, input logic e_tfl,
                            input logic e_fault);
    check({tag, ".state"}, 32'(state), 32'(e_state));
    check({tag, ".mt"},    32'(mt),    32'(e_mt));
    check({tag, ".md"},    32'(md),    32'(e_md));
    check({tag, ".al"},    32'(al),    32'(e_al));
    check({tag, ".tfl"},   32'(tfl),   32'(e_tfl));
    check({tag, ".fault"}, 32'(fault), 32'(e_fault));
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    request = 1'b0; deck = 4'b0; top_limit = 1'b0; bot_limit = 1'b0; estop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Request from DOWN, then run through WARN into LIFT with an empty deck.
  task automatic go_to_lift();
    request = 1'b1;
    ticks(1 + 8);
  endtask

  initial begin
    rst_n = 1'b0;
    request = 1'b0; deck = 4'b0; top_limit = 1'b0; bot_limit = 1'b0; estop = 1'b0;
    #1;
    check_outs("reset", DOWN, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_outs("idle", DOWN, 0, 0, 0, 0, 0);

    // Request -> WARN next edge, LIFT 8 cycles later
    request = 1'b1;
    tick();
    check_outs("warn_entry", WARN, 0, 0, 1, 1, 0);
    ticks(7);
    check_outs("warn_c7", WARN, 0, 0, 1, 1, 0);
    tick();
    check_outs("lift_entry", LIFT, 1, 0, 1, 1, 0);

    // Deck occupied during LIFT pauses the motor for exactly those cycles
    ticks(2);
    deck = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("lift_pause", LIFT, 0, 0, 1, 1, 0);
    end
    deck = 4'b0;
    tick();
    check_outs("lift_resume", LIFT, 1, 0, 1, 1, 0);

    // Top limit -> UP; request held keeps it UP
    top_limit = 1'b1;
    tick();
    check_outs("up_entry", UP, 0, 0, 0, 1, 0);
    top_limit = 1'b0;
    ticks(40);
    check_outs("up_held", UP, 0, 0, 0, 1, 0);
    request = 1'b0;
    tick();
    check_outs("lower_entry", LOWER, 0, 1, 1, 1, 0);

    // A new request does not reverse the span. The deck pauses the lower motor.
    request = 1'b1;
    tick();
    check_outs("lower_noreverse", LOWER, 0, 1, 1, 1, 0);
    deck = 4'b0001;
    tick();
    check_outs("lower_pause", LOWER, 0, 0, 1, 1, 0);
    deck = 4'b0;
    request = 1'b0;
    bot_limit = 1'b1;
    tick();
    check_outs("down_again", DOWN, 0, 0, 0, 0, 0);
    bot_limit = 1'b0;

    // An occupied deck in WARN restarts the clearing period
    request = 1'b1;
    tick();
    ticks(5);
    deck = 4'b0010;
    tick();
    check_outs("warn_deck", WARN, 0, 0, 1, 1, 0);
    deck = 4'b0;
    ticks(7);
    check_outs("warn_restart7", WARN, 0, 0, 1, 1, 0);
    tick();
    check_outs("lift_after_restart", LIFT, 1, 0, 1, 1, 0);

    // UP with request low lowers after 16 cycles
    top_limit = 1'b1;
    request = 1'b0;
    tick();
    top_limit = 1'b0;
    check_outs("up2", UP, 0, 0, 0, 1, 0);
    ticks(15);
    check_outs("up2_c15", UP, 0, 0, 0, 1, 0);
    tick();
    check_outs("lower2", LOWER, 0, 1, 1, 1, 0);

    // EStop during LOWER -> FAULT, which is sticky
    estop = 1'b1;
    tick();
    check_outs("estop_fault", FAULT, 0, 0, 1, 1, 1);
    estop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      request = ~request;
      tick();
    end
    check_outs("fault_sticky", FAULT, 0, 0, 1, 1, 1);

    // Asynchronous reset in mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", DOWN, 0, 0, 0, 0, 0);
    request = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // A WARN request withdrawn returns to DOWN
    request = 1'b1;
    tick();
    request = 1'b0;
    tick();
    check_outs("warn_abort", DOWN, 0, 0, 0, 0, 0);

    // Motor timeout: the 64th motor cycle without top limit -> FAULT
    go_to_lift();
    check_outs("lift3", LIFT, 1, 0, 1, 1, 0);
    ticks(63);
    check_outs("lift3_c63", LIFT, 1, 0, 1, 1, 0);
    tick();
    check_outs("timeout_fault", FAULT, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      request = ~request;
      tick();
    end
    check_outs("timeout_sticky", FAULT, 0, 0, 1, 1, 1);

    // Both limits together -> FAULT from DOWN
    do_reset();
    top_limit = 1'b1;
    bot_limit = 1'b1;
    tick();
    check_outs("limits_fault", FAULT, 0, 0, 1, 1, 1);

    // Reset while the raise motor runs stops it without a clock
    do_reset();
    go_to_lift();
    ticks(3);
    check_outs("lift4", LIFT, 1, 0, 1, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("reset_motor", DOWN, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_outs("resume_warn", WARN, 0, 0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/drawbridge_ctrl.md
DRAWBRIDGE_CTRL -- requirements
Module: drawbridge_ctrl

Interface
REQ-001 Parameter N_DECK, default 4: number of deck occupancy sensors.
REQ-002 Parameter CNT_W, default 8: width of the shared cycle counter.
REQ-003 Parameter CLEAR_TIME, default 8: cycles the deck must stay empty before lifting.
REQ-004 Parameter HOLD_TIME, default 16: minimum cycles held upright.
REQ-005 Parameter MOTOR_TIMEOUT, default 64: maximum motor-active cycles per movement.
REQ-006 Each of CLEAR_TIME, HOLD_TIME and MOTOR_TIMEOUT SHALL be >=1 and <=2^CNT_W-2.
REQ-007 Clock  in  1  rising-edge system clock.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 Request  in  1  boat passage request, level-sensitive.
REQ-010 Deck  in  N_DECK  deck occupancy sensors, 1 = occupied.
REQ-011 TopLimit  in  1  span fully raised.
REQ-012 BotLimit  in  1  span fully lowered.
REQ-013 EStop  in  1  emergency stop.
REQ-014 MT  out  1  raise motor on.
REQ-015 MD  out  1  lower motor on.
REQ-016 AL  out  1  alarm on.
REQ-017 TFL  out  1  road traffic light, 1 = red.
REQ-018 State  out  3  current state: DOWN=0, WARN=1, LIFT=2, UP=3, LOWER=4, FAULT=5.
REQ-019 Fault  out  1  sticky fault indicator.

Function
REQ-020 All outputs SHALL be registered and update on the same Clock edge as State, reflecting the new state and the inputs sampled at that edge.
REQ-021 Inputs SHALL be sampled on the rising edge of Clock; a state change SHALL appear one cycle after the causing input.
REQ-022 Transition priority SHALL be: EStop, then TopLimit&BotLimit both 1, then motor timeout, then normal transitions.
REQ-023 EStop=1 or TopLimit=BotLimit=1 in any state SHALL move to FAULT.
REQ-024 The shared counter SHALL clear to 0 on every state change, increment by 1 each cycle otherwise, and saturate at all-ones without wrapping.
REQ-025 DOWN: MT=MD=AL=0, TFL=0; Request=1 SHALL move to WARN.
REQ-026 WARN: AL=1, TFL=1, motors off; a Deck bit set SHALL clear the counter.
REQ-027 WARN: Request=0 SHALL return to DOWN, with precedence over the lift transition.
REQ-028 WARN: counter = CLEAR_TIME-1 with Deck=0 in the same cycle SHALL move to LIFT.
REQ-029 LIFT: AL=1, TFL=1, MD=0; MT=1 only while Deck=0; any Deck bit set SHALL pause the motor (MT=0) and freeze the counter.
REQ-030 LIFT: TopLimit=1 SHALL move to UP; counter = MOTOR_TIMEOUT-1 without TopLimit SHALL move to FAULT.
REQ-031 UP: MT=MD=AL=0, TFL=1; counter >= HOLD_TIME-1 with Request=0 SHALL move to LOWER.
REQ-032 UP: Request held high SHALL keep the state at UP indefinitely.
REQ-033 LOWER: AL=1, TFL=1, MT=0; MD=1 only while Deck=0; Deck pause and counter freeze SHALL be as in LIFT.
REQ-034 LOWER: BotLimit=1 SHALL move to DOWN; timeout SHALL be as in LIFT.
REQ-035 LOWER: Request=1 SHALL NOT reverse the span; lowering completes first.
REQ-036 FAULT: MT=MD=0, AL=1, TFL=1, Fault=1; FAULT SHALL be exited only by Reset.
REQ-037 MT and MD SHALL never both be 1.

Reset
REQ-038 Reset=0 SHALL immediately, without Clock, force State=DOWN, counter=0, MT=MD=AL=TFL=Fault=0.
REQ-039 Reset asserted mid-movement SHALL stop the motors asynchronously.
REQ-040 After release, the block SHALL resume from DOWN on the first rising edge with Reset=1.

Verification
REQ-041 Defaults; Request=1, Deck=0 -> WARN next cycle, LIFT 8 cycles later with MT=1, AL=1, TFL=1.
REQ-042 In WARN, Deck=4'b0010 at counter 5 -> counter clears; LIFT only after 8 further empty cycles.
REQ-043 In LIFT, Deck=4'b1000 for 3 cycles -> MT=0, AL=1 for those cycles; the counter holds and the motor resumes afterwards.
REQ-044 In LIFT, TopLimit never asserted -> FAULT after 64 motor cycles with Fault=1, MT=0; Request toggling has no effect until Reset.
REQ-045 Full cycle: UP with Request=0 -> LOWER after 16 cycles, MD=1; BotLimit=1 -> DOWN with TFL=0.
REQ-046 EStop=1 during LOWER -> FAULT next edge with MD=0; Reset=0 mid-cycle -> all outputs 0 and State=0 asynchronously.
